// File: rtl/subservient_timer.sv
// subservient_timer
//   Wishbone timer peripheral for the subservient SoC extension bus.
//   It holds a free-running 32-bit mtime with a programmable prescaler
//   and a 32-bit mtimecmp. It raises a level timer interrupt while
//   IRQ_EN is set and mtime >= mtimecmp.
//
//   Register map (adr[3:2]; all other address bits ignored):
//     0 MTIME     rw
//     1 MTIMECMP  rw
//     2 CTRL      rw  bit0 EN, bit1 IRQ_EN, [8+PRESCALE_W-1:8] DIV
//     3 STATUS    ro  bit0 mtime>=mtimecmp, bit1 o_timer_irq
//
// Ports
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_wb_adr/dat/sel/we  request fields, held stable by master until ack
//   i_wb_stb             request strobe (no cyc)
//   o_wb_rdt             read data, valid in ack cycle only (else 0)
//   o_wb_ack             one-cycle acknowledge, one cycle after stb
//   o_timer_irq          registered level interrupt
//
// PRESCALE_W must be in 1..16 so DIV fits in CTRL bits [23:8].
module subservient_timer #(
  parameter int PRESCALE_W = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_timer_irq
);

  localparam logic [1:0] A_MTIME    = 2'd0;
  localparam logic [1:0] A_MTIMECMP = 2'd1;
  localparam logic [1:0] A_CTRL     = 2'd2;
  localparam logic [1:0] A_STATUS   = 2'd3;

  // Implemented CTRL bits; everything else stays 0.
  localparam logic [31:0] CTRL_MASK =
    32'h3 | (((32'h1 << PRESCALE_W) - 32'h1) << 8);
  localparam logic [PRESCALE_W-1:0] P_ONE = 1;

  logic [31:0]           mtime, mtimecmp, ctrl;
  logic [PRESCALE_W-1:0] pcnt;

  logic                  en, irq_en;
  logic [PRESCALE_W-1:0] div;
  assign en     = ctrl[0];
  assign irq_en = ctrl[1];
  assign div    = ctrl[8 +: PRESCALE_W];

  // A request is taken in the cycle before ack rises. Gating with ~ack
  // makes a held stb produce one ack every other cycle.
  logic        req, wr, tick, cmp_hit;
  logic [31:0] wmask, rdata;
  assign req     = i_wb_stb & ~o_wb_ack;
  assign wr      = req & i_wb_we;
  assign wmask   = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}},
                    {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
  assign tick    = en & (pcnt == div);
  assign cmp_hit = (mtime >= mtimecmp);

  logic unused_adr;
  assign unused_adr = ^{i_wb_adr[31:4], i_wb_adr[1:0]};

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] dat,
                                        input logic [31:0] msk);
    return (old & ~msk) | (dat & msk);
  endfunction

  always_comb begin
    rdata = '0;
    case (i_wb_adr[3:2])
      A_MTIME:    rdata = mtime;
      A_MTIMECMP: rdata = mtimecmp;
      A_CTRL:     rdata = ctrl;
      A_STATUS:   rdata = {30'd0, o_timer_irq, cmp_hit};
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mtime       <= '0;
      mtimecmp    <= '1;
      ctrl        <= '0;
      pcnt        <= '0;
      o_wb_ack    <= 1'b0;
      o_wb_rdt    <= '0;
      o_timer_irq <= 1'b0;
    end else begin
      o_wb_ack    <= req;
      o_wb_rdt    <= (req & ~i_wb_we) ? rdata : '0;
      o_timer_irq <= irq_en & cmp_hit;

      // A software write to MTIME suppresses that cycle's increment.
      if (wr && i_wb_adr[3:2] == A_MTIME)
        mtime <= merge(mtime, i_wb_dat, wmask);
      else if (tick)
        mtime <= mtime + 32'd1;

      if (wr && i_wb_adr[3:2] == A_MTIMECMP)
        mtimecmp <= merge(mtimecmp, i_wb_dat, wmask);

      // Any CTRL write restarts the prescale period, whatever sel is.
      if (wr && i_wb_adr[3:2] == A_CTRL) begin
        ctrl <= merge(ctrl, i_wb_dat, wmask) & CTRL_MASK;
        pcnt <= '0;
      end else if (en) begin
        pcnt <= tick ? '0 : pcnt + P_ONE;
      end
    end
  end

endmodule

// File: tb/tb_subservient_timer.sv
// Self-checking bench for subservient_timer: a vector table for the
// register file behaviour plus hand-written timing sequences. Read
// expectations go into a scoreboard queue when a request is driven and
// are popped by a monitor on every ack.
module tb_subservient_timer;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] wb_adr = '0, wb_dat = '0;
  logic [3:0]  wb_sel = '0;
  logic        wb_we = 1'b0, wb_stb = 1'b0;
  logic [31:0] wb_rdt;
  logic        wb_ack, irq;
  int          cyc = 0, n_cmp = 0, n_bad = 0;

  subservient_timer #(.PRESCALE_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(wb_adr), .i_wb_dat(wb_dat),
    .i_wb_sel(wb_sel), .i_wb_we(wb_we), .i_wb_stb(wb_stb),
    .o_wb_rdt(wb_rdt), .o_wb_ack(wb_ack), .o_timer_irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        c;
    logic [31:0] e;
    string       nm;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        we;
    logic [1:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        c;
    logic [31:0] e;
    string       nm;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  // Monitor: every ack consumes one scoreboard entry.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (wb_ack === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL stray_ack: got ack=1, want ack=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        if (e.c) chk(e.nm, wb_rdt, e.e);
      end
    end
  end

  // One idle cycle, then the request; ack is due one cycle later, so the
  // ack edge is always (cycle at call) + 2.
  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic c, input logic [31:0] e,
                     input string nm, output int ack_cyc);
    exp_t x;
    int   n;
    @(posedge clk); #1;
    x.c = c; x.e = e; x.nm = nm;
    sb.push_back(x);
    wb_we  = w;
    wb_adr = $urandom();
    wb_adr[3:2] = a;
    wb_dat = d;
    wb_sel = s;
    wb_stb = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (wb_ack !== 1'b1 && n < 8);
    ack_cyc = cyc;
    if (wb_ack !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: no ack after %0d cycles, want ack after 1", nm, n);
      void'(sb.pop_back());
    end else begin
      chk({nm, "_lat"}, 32'(n), 32'd1);
    end
    wb_stb = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                    output int ac);
    bus(1'b1, a, d, s, 1'b0, 32'h0, "wr", ac);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
    int ac;
    bus(1'b0, a, 32'h0, 4'hF, 1'b1, e, nm, ac);
  endtask

  task automatic add(input logic we, input logic [1:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic c, input logic [31:0] e,
                     input string nm);
    vec_t v;
    v.we = we; v.adr = a; v.dat = d; v.sel = s; v.c = c; v.e = e; v.nm = nm;
    tv.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          c0, f, ac;
    logic [31:0] m, frozen;

    // Register-file vectors (timer disabled throughout)
    add(0, 2'd0, 32'h0,        4'hF, 1, 32'h0000_0000, "mtime_rst");
    add(0, 2'd1, 32'h0,        4'hF, 1, 32'hFFFF_FFFF, "cmp_rst");
    add(0, 2'd2, 32'h0,        4'hF, 1, 32'h0000_0000, "ctrl_rst");
    add(0, 2'd3, 32'h0,        4'hF, 1, 32'h0000_0000, "status_rst");
    add(1, 2'd1, 32'h1234_5678, 4'h5, 0, 32'h0,        "wr");
    add(0, 2'd1, 32'h0,        4'hF, 1, 32'hFF34_FF78, "cmp_bytes");
    add(1, 2'd2, 32'hFFFF_FFFC, 4'hF, 0, 32'h0,        "wr");
    add(0, 2'd2, 32'h0,        4'hF, 1, 32'h0000_FF00, "ctrl_mask");
    add(1, 2'd2, 32'h0,        4'h2, 0, 32'h0,        "wr");
    add(0, 2'd2, 32'h0,        4'hF, 1, 32'h0000_0000, "ctrl_byte");
    add(1, 2'd3, 32'hFFFF_FFFF, 4'hF, 0, 32'h0,        "wr");
    add(0, 2'd3, 32'h0,        4'hF, 1, 32'h0000_0000, "status_ro");
    add(1, 2'd0, 32'hDEAD_BEEF, 4'hC, 0, 32'h0,        "wr");
    add(0, 2'd0, 32'h0,        4'hF, 1, 32'hDEAD_0000, "mtime_bytes");
    add(1, 2'd1, 32'h0,        4'hF, 0, 32'h0,        "wr");
    add(0, 2'd3, 32'h0,        4'hF, 1, 32'h0000_0001, "status_cmp");
    add(1, 2'd1, 32'hDEAD_0001, 4'hF, 0, 32'h0,        "wr");
    add(0, 2'd3, 32'h0,        4'hF, 1, 32'h0000_0000, "status_cmp_gt");
    add(1, 2'd1, 32'hDEAD_0000, 4'hF, 0, 32'h0,        "wr");
    add(0, 2'd3, 32'h0,        4'hF, 1, 32'h0000_0001, "status_cmp_eq");

    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    chk1("rst_ack", wb_ack, 1'b0);
    chk("rst_rdt", wb_rdt, 32'h0);
    chk1("rst_irq", irq, 1'b0);

    foreach (tv[i]) begin
      bus(tv[i].we, tv[i].adr, tv[i].dat, tv[i].sel, tv[i].c, tv[i].e, tv[i].nm, ac);
      chk1("irq_idle", irq, 1'b0);
    end

    // Prescaled count, DIV=3: ticks at c0+4k
    wr(2'd0, 32'h0, 4'hF, ac);
    wr(2'd1, 32'hFFFF_FFFF, 4'hF, ac);
    wr(2'd2, 32'h0000_0301, 4'hF, c0);
    repeat (40) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      m = 32'((cyc + 2 - 1 - c0) / 4);
      rd(2'd0, m, "presc_cnt");
    end
    wr(2'd2, 32'h0, 4'hF, f);
    frozen = 32'((f - c0) / 4);
    rd(2'd0, frozen, "frozen_a");
    repeat (20) @(posedge clk);
    #1;
    rd(2'd0, frozen, "frozen_b");

    // IRQ assert and clear, DIV=0
    wr(2'd0, 32'h0, 4'hF, ac);
    wr(2'd1, 32'h5, 4'hF, ac);
    wr(2'd2, 32'h3, 4'hF, c0);
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      chk1("irq_rise", irq, (cyc - c0) >= 6);
    end
    wr(2'd1, 32'h100, 4'hF, ac);
    chk1("irq_hold", irq, 1'b1);
    @(posedge clk); #1;
    chk1("irq_clear", irq, 1'b0);
    wr(2'd2, 32'h0, 4'hF, ac);

    // Pending IRQ drops after mtime wraps past mtimecmp
    wr(2'd1, 32'hFFFF_FFF8, 4'hF, ac);
    wr(2'd0, 32'hFFFF_FFFA, 4'hF, ac);
    wr(2'd2, 32'h3, 4'hF, c0);
    for (int j = 0; j < 9; j++) begin
      @(posedge clk); #1;
      m = 32'hFFFF_FFFA + 32'(cyc - c0 - 1);
      chk1("irq_wrap", irq, m >= 32'hFFFF_FFF8);
    end
    wr(2'd2, 32'h0, 4'hF, ac);

    // mtime wrap on read
    wr(2'd0, 32'hFFFF_FFFE, 4'hF, ac);
    wr(2'd2, 32'h1, 4'hF, c0);
    @(posedge clk); #1;
    rd(2'd0, 32'hFFFF_FFFE + 32'(cyc + 2 - c0 - 1), "wrap_zero");
    wr(2'd2, 32'h0, 4'hF, ac);

    // Software write lands on the same edge as a tick
    wr(2'd0, 32'h0, 4'hF, ac);
    wr(2'd2, 32'h0000_0301, 4'hF, c0);
    repeat (2) @(posedge clk);
    #1;
    wr(2'd0, 32'h0000_00AA, 4'hF, ac);
    chk("coll_timing", 32'(ac), 32'(c0 + 4));
    rd(2'd0, 32'h0000_00AA, "coll_val");
    wr(2'd2, 32'h0, 4'hF, ac);

    // Held strobe: ack every other cycle
    wr(2'd0, 32'h0000_0055, 4'hF, ac);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      exp_t x;
      x.c = 1'b1; x.e = 32'h0000_0055; x.nm = "hs_rdt";
      sb.push_back(x);
    end
    wb_we = 1'b0; wb_adr = 32'h0; wb_sel = 4'hF; wb_stb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk1("hs_ack", wb_ack, (i % 2) == 1);
      if ((i % 2) == 0) chk("hs_rdt_idle", wb_rdt, 32'h0);
      @(posedge clk); #1;
    end
    wb_stb = 1'b0;

    // Reset in the cycle before the ack drops the request
    @(posedge clk); #1;
    wb_we = 1'b0; wb_adr = 32'h4; wb_stb = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    chk1("rst_no_ack", wb_ack, 1'b0);
    rst = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    chk1("rst_no_ack2", wb_ack, 1'b0);
    rd(2'd0, 32'h0, "mtime_post_rst");
    rd(2'd1, 32'hFFFF_FFFF, "cmp_post_rst");
    rd(2'd3, 32'h0, "status_post_rst");

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
